// File: rtl/core_int_pkg.sv
//------------------------------------------------------------------------------
// Module  : core_int_pkg
// Brief   : Shared types and constants for the core interrupt responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_int_pkg;

  localparam int XLEN_DEF = 32;

  typedef logic [XLEN_DEF-1:0] pc_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PENDING  = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_HANDLER  = 3'd3,
    ST_RETURN   = 3'd4
  } core_int_state_t;

endpackage

`default_nettype wire

// File: rtl/core_int_unit.sv
//------------------------------------------------------------------------------
// Module  : core_int_unit
// Brief   : Core-side interrupt responder: takes requests at a retire boundary,
//           redirects fetch to the handler and back on interrupt-return.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_int_unit
  import core_int_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signal_interrupt,
  input  logic [XLEN-1:0]    interrupt_pc,
  output logic               int_accepted,
  output logic               interrupt_serviced,
  input  logic               global_int_en,
  input  logic               commit_valid,
  input  logic [XLEN-1:0]    commit_next_pc,
  input  logic               commit_is_iret,
  output logic               flush,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  input  logic               redirect_ready,
  output logic [XLEN-1:0]    epc,
  output logic               in_handler,
  output logic [COUNT_W-1:0] int_taken_count
);

  core_int_state_t    r_state;
  core_int_state_t    w_state_nxt;
  logic [XLEN-1:0]    r_handler_pc;
  logic [XLEN-1:0]    r_epc;
  logic [COUNT_W-1:0] r_count;

  logic w_capture_req;
  logic w_take;
  logic w_accept;

  assign w_capture_req = (r_state == ST_IDLE) && signal_interrupt;
  // A retiring instruction is the precise boundary only while interrupts are enabled.
  assign w_take        = (r_state == ST_PENDING) && global_int_en && commit_valid;
  assign w_accept      = (r_state == ST_REDIRECT) && redirect_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_handler_pc <= '0;
      r_epc        <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture_req) r_handler_pc <= interrupt_pc;
      if (w_take)        r_epc        <= commit_next_pc;
      if (w_accept)      r_count      <= r_count + COUNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    flush              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    int_accepted       = 1'b0;
    interrupt_serviced = 1'b0;
    in_handler         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (signal_interrupt) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_take) begin
          flush       = 1'b1;
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_handler_pc;
        if (redirect_ready) begin
          int_accepted = 1'b1;
          w_state_nxt  = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
        if (commit_valid && commit_is_iret) begin
          flush       = 1'b1;
          w_state_nxt = ST_RETURN;
        end
      end
      ST_RETURN: begin
        in_handler     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_epc;
        if (redirect_ready) begin
          interrupt_serviced = 1'b1;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign epc             = r_epc;
  assign int_taken_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_core_int_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_core_int_unit
// Brief   : Self-checking bench for core_int_unit with a transaction-level model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_int_unit;

  localparam int XLEN    = 32;
  localparam int COUNT_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               signal_interrupt;
  logic [XLEN-1:0]    interrupt_pc;
  logic               int_accepted;
  logic               interrupt_serviced;
  logic               global_int_en;
  logic               commit_valid;
  logic [XLEN-1:0]    commit_next_pc;
  logic               commit_is_iret;
  logic               flush;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               redirect_ready;
  logic [XLEN-1:0]    epc;
  logic               in_handler;
  logic [COUNT_W-1:0] int_taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: last saved return PC and interrupts taken mod 2^COUNT_W.
  logic [XLEN-1:0] m_epc;
  int              m_count;

  core_int_unit #(.XLEN(XLEN), .COUNT_W(COUNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .signal_interrupt  (signal_interrupt),
    .interrupt_pc      (interrupt_pc),
    .int_accepted      (int_accepted),
    .interrupt_serviced(interrupt_serviced),
    .global_int_en     (global_int_en),
    .commit_valid      (commit_valid),
    .commit_next_pc    (commit_next_pc),
    .commit_is_iret    (commit_is_iret),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready),
    .epc               (epc),
    .in_handler        (in_handler),
    .int_taken_count   (int_taken_count)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    signal_interrupt = 1'b0;
    interrupt_pc     = '0;
    global_int_en    = 1'b0;
    commit_valid     = 1'b0;
    commit_next_pc   = '0;
    commit_is_iret   = 1'b0;
    redirect_ready   = 1'b0;
  endtask

  task automatic pulse_request(input logic [XLEN-1:0] hpc);
    next_cycle();
    idle_inputs();
    signal_interrupt = 1'b1;
    interrupt_pc     = hpc;
  endtask

  // Starts with the request pulse on the inputs; walks hold, take, accept, handler, return.
  task automatic finish_interrupt(input logic [XLEN-1:0] hpc, input logic [XLEN-1:0] npc,
                                  input int hold, input int acc_stall, input int ret_stall,
                                  input int body);
    logic [XLEN-1:0] old_epc;
    old_epc = m_epc;
    for (int i = 0; i < hold; i++) begin
      next_cycle();
      idle_inputs();
      commit_valid   = 1'($urandom_range(0, 1));
      commit_next_pc = $urandom;
      commit_is_iret = 1'($urandom_range(0, 1));
      redirect_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (flush !== 1'b0 || redirect_valid !== 1'b0 || int_accepted !== 1'b0 ||
          interrupt_serviced !== 1'b0 || epc !== old_epc) begin
        n_fail++;
        $display("FAIL pending_hold cyc%0d: flush=%b rv=%b acc=%b svc=%b epc=%h, required 0 0 0 0 %h",
                 i, flush, redirect_valid, int_accepted, interrupt_serviced, epc, old_epc);
      end
    end
    next_cycle();
    idle_inputs();
    global_int_en  = 1'b1;
    commit_valid   = 1'b1;
    commit_next_pc = npc;
    #1;
    n_checks++;
    if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL take_flush: flush=%b rv=%b, required 1 0", flush, redirect_valid);
    end
    m_epc = npc;
    for (int i = 0; i < acc_stall; i++) begin
      next_cycle();
      idle_inputs();
      global_int_en = 1'($urandom_range(0, 1));
      commit_valid  = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== hpc || int_accepted !== 1'b0 || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_wait: rv=%b pc=%h acc=%b flush=%b, required 1 %h 0 0",
                 redirect_valid, redirect_pc, int_accepted, flush, hpc);
      end
    end
    next_cycle();
    idle_inputs();
    redirect_ready = 1'b1;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== hpc || int_accepted !== 1'b1) begin
      n_fail++;
      $display("FAIL accept: rv=%b pc=%h acc=%b, required 1 %h 1",
               redirect_valid, redirect_pc, int_accepted, hpc);
    end
    m_count = (m_count + 1) % (1 << COUNT_W);
    for (int i = 0; i <= body; i++) begin
      next_cycle();
      idle_inputs();
      global_int_en    = 1'($urandom_range(0, 1));
      signal_interrupt = 1'($urandom_range(0, 1));
      commit_valid     = 1'($urandom_range(0, 1));
      commit_next_pc   = $urandom;
      #1;
      n_checks++;
      if (int_accepted !== 1'b0 || in_handler !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
          epc !== m_epc || int_taken_count !== COUNT_W'(m_count)) begin
        n_fail++;
        $display("FAIL handler: acc=%b inh=%b flush=%b rv=%b epc=%h cnt=%0d, required 0 1 0 0 %h %0d",
                 int_accepted, in_handler, flush, redirect_valid, epc, int_taken_count, m_epc, m_count);
      end
    end
    next_cycle();
    idle_inputs();
    commit_valid   = 1'b1;
    commit_is_iret = 1'b1;
    #1;
    n_checks++;
    if (flush !== 1'b1 || interrupt_serviced !== 1'b0) begin
      n_fail++;
      $display("FAIL iret_flush: flush=%b svc=%b, required 1 0", flush, interrupt_serviced);
    end
    for (int i = 0; i < ret_stall; i++) begin
      next_cycle();
      idle_inputs();
      #1;
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== m_epc || interrupt_serviced !== 1'b0 ||
          in_handler !== 1'b1) begin
        n_fail++;
        $display("FAIL return_wait: rv=%b pc=%h svc=%b inh=%b, required 1 %h 0 1",
                 redirect_valid, redirect_pc, interrupt_serviced, in_handler, m_epc);
      end
    end
    next_cycle();
    idle_inputs();
    redirect_ready = 1'b1;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== m_epc || interrupt_serviced !== 1'b1) begin
      n_fail++;
      $display("FAIL serviced: rv=%b pc=%h svc=%b, required 1 %h 1",
               redirect_valid, redirect_pc, interrupt_serviced, m_epc);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (interrupt_serviced !== 1'b0 || in_handler !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== '0 || epc !== m_epc) begin
      n_fail++;
      $display("FAIL back_idle: svc=%b inh=%b rv=%b pc=%h epc=%h, required 0 0 0 0 %h",
               interrupt_serviced, in_handler, redirect_valid, redirect_pc, epc, m_epc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if (int_accepted !== 1'b0 || interrupt_serviced !== 1'b0 || flush !== 1'b0 ||
        redirect_valid !== 1'b0 || redirect_pc !== '0 || in_handler !== 1'b0 ||
        epc !== '0 || int_taken_count !== '0) begin
      n_fail++;
      $display("FAIL %s: acc=%b svc=%b flush=%b rv=%b pc=%h inh=%b epc=%h cnt=%0d, required all 0",
               tag, int_accepted, interrupt_serviced, flush, redirect_valid, redirect_pc,
               in_handler, epc, int_taken_count);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) next_cycle();
    #1;
    check_reset_state("reset_state");
    rst = 1'b0;
    m_epc   = '0;
    m_count = 0;
  endtask

  task automatic test_basic_take();
    pulse_request(32'h0000_1000);
    finish_interrupt(32'h0000_1000, 32'h0000_0240, 1, 0, 0, 0);
  endtask

  task automatic test_disabled_hold();
    pulse_request(32'h0000_2000);
    finish_interrupt(32'h0000_2000, 32'h0000_3344, 20, 1, 0, 2);
  endtask

  task automatic test_return_stall();
    pulse_request(32'h0000_1000);
    finish_interrupt(32'h0000_1000, 32'h0000_0240, 0, 0, 3, 1);
  endtask

  task automatic test_iret_outside();
    logic [XLEN-1:0] old_epc;
    old_epc = m_epc;
    next_cycle();
    idle_inputs();
    global_int_en  = 1'b1;
    commit_valid   = 1'b1;
    commit_is_iret = 1'b1;
    commit_next_pc = 32'hdead_beef;
    #1;
    n_checks++;
    if (flush !== 1'b0 || interrupt_serviced !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL iret_idle: flush=%b svc=%b rv=%b, required 0 0 0", flush, interrupt_serviced, redirect_valid);
    end
    pulse_request(32'h0000_5000);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle_inputs();
      commit_valid   = 1'b1;
      commit_is_iret = 1'b1;
      commit_next_pc = $urandom;
      #1;
      n_checks++;
      if (flush !== 1'b0 || interrupt_serviced !== 1'b0 || epc !== old_epc) begin
        n_fail++;
        $display("FAIL iret_pending: flush=%b svc=%b epc=%h, required 0 0 %h",
                 flush, interrupt_serviced, epc, old_epc);
      end
    end
    finish_interrupt(32'h0000_5000, 32'h0000_5678, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    pulse_request(32'h0000_7000);
    next_cycle();
    idle_inputs();
    global_int_en  = 1'b1;
    commit_valid   = 1'b1;
    commit_next_pc = 32'h0000_7777;
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_redirect: rv=%b, required 1", redirect_valid);
    end
    #1 rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    m_epc   = '0;
    m_count = 0;
    next_cycle();
    rst = 1'b0;
    pulse_request(32'h0000_8000);
    finish_interrupt(32'h0000_8000, 32'h0000_8888, 2, 1, 1, 1);
  endtask

  task automatic test_counter_wrap();
    for (int k = 0; k < 5; k++) begin
      pulse_request(32'h0000_9000 + 32'(k * 16));
      finish_interrupt(32'h0000_9000 + 32'(k * 16), 32'h0000_a000 + 32'(k * 4), 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] hpc;
    logic [XLEN-1:0] npc;
    for (int k = 0; k < 8; k++) begin
      hpc = $urandom;
      npc = $urandom;
      pulse_request(hpc);
      finish_interrupt(hpc, npc, $urandom_range(0, 5), $urandom_range(0, 4),
                       $urandom_range(0, 4), $urandom_range(0, 5));
      repeat ($urandom_range(0, 3)) next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic_take();
    test_disabled_hold();
    test_return_stall();
    test_iret_outside();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
